// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory stage that sits directly after the ALU. The ALU result is the
// effective address and rs2 is the store data. One load or store is in flight
// at a time on a valid/ready data bus. Aligned, sign- or zero-extended load
// data (or a store acknowledge) goes back to writeback as a single-cycle pulse.
// Upstream is blocked whenever the unit is not idle.
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   : a misaligned half/word or size=11 faults without touching the
//               bus (resp_err=1, resp_data=address, resp_rd=0).
//   undefined : no fault; half ignores addr[0], word ignores addr[1:0] and
//               size=11 behaves as a word access.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both high. A valid, once raised, holds its payload stable until that edge.
// mem_rvalid needs no ready; it is honoured only while waiting for a response.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   execute-stage request handshake (ready == idle)
//   req_load/size/unsigned/addr/wdata/rd   request payload
//   flush                 squash the in-flight response; blocks new accepts
//   mem_valid/mem_ready   bus request handshake
//   mem_addr/we/wstrb/wdata   bus request payload (word address, lane data)
//   mem_rvalid/mem_rdata  bus response (read data or write ack)
//   resp_valid/rd/data/err    writeback result pulse
//   dbg_state             current FSM state (IDLE=0, REQ=1, WAIT=2, RESP=3)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] result_q, result_d;
    logic        load_q, load_d;
    logic        uns_q, uns_d;
    logic        squash_q, squash_d;
    logic        err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        accept;
    logic        misalign;
    logic [3:0]  lane_strb;
    logic [31:0] lane_data;
    logic [1:0]  byte_sel;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign accept = req_valid & req_ready & ~flush;

`ifdef MISALIGN_TRAP_EN
    assign misalign = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (|req_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    // Store lane steering from the latched op. Half accesses only look at
    // addr[1] so an odd half address lands on the lower/upper half-word.
    always_comb begin
        lane_strb = 4'hF;
        lane_data = wdata_q;
        case (size_q)
            2'b00: begin
                lane_strb = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_strb = 4'b0011 << {addr_q[1], 1'b0};
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_strb = 4'hF;
                lane_data = wdata_q;
            end
        endcase
        if (load_q) begin
            lane_strb = 4'h0;
        end
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        byte_sel = (size_q == 2'b01) ? {addr_q[1], 1'b0} : addr_q[1:0];
        shifted  = mem_rdata >> {byte_sel, 3'b000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        load_d   = load_q;
        uns_d    = uns_q;
        squash_d = squash_q;
        err_d    = err_q;
        size_d   = size_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    load_d   = req_load;
                    uns_d    = req_unsigned;
                    size_d   = req_size;
                    rd_d     = req_rd;
                    squash_d = 1'b0;
                    cnt_d    = 8'd0;
                    if (misalign) begin
                        // Fault without a bus access.
                        err_d    = 1'b1;
                        result_d = req_addr;
                        state_d  = S_RESP;
                    end else begin
                        err_d    = 1'b0;
                        result_d = 32'd0;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mem_ready) begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mem_rvalid) begin
                    err_d    = 1'b0;
                    result_d = load_q ? load_ext : 32'd0;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d    = 1'b1;
                    result_d = addr_q;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                squash_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            result_q <= 32'd0;
            load_q   <= 1'b0;
            uns_q    <= 1'b0;
            squash_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            rd_q     <= 5'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            load_q   <= load_d;
            uns_q    <= uns_d;
            squash_q <= squash_d;
            err_q    <= err_d;
            size_q   <= size_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Bus payload is only driven while requesting, so it reads as zero
    // everywhere else (including straight out of reset).
    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = (state_q == S_REQ);
    assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_we     = mem_valid & ~load_q;
    assign mem_wstrb  = mem_valid ? lane_strb : 4'h0;
    assign mem_wdata  = mem_valid ? lane_data : 32'd0;

    // A squashed op still walks through RESP, just without the pulse.
    assign resp_valid = (state_q == S_RESP) & ~squash_q;
    assign resp_err   = resp_valid & err_q;
    assign resp_data  = resp_valid ? result_q : 32'd0;
    assign resp_rd    = (resp_valid & load_q & ~err_q) ? rd_q : 5'd0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed and randomized load/store traffic against load_store_unit built
// with TIMEOUT_CYCLES=4. Expected results come from a behavioural model of
// the memory-stage rules (lane arithmetic, extension, faults); each expected
// response is queued when the op is issued and popped when it is returned.
// Inputs are driven and outputs sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected response: {err, rd, data}
    logic [37:0] exp_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_load     (req_load),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v;
        int unsigned lane;
        if (sz == 2'd0) begin
            lane = a % 4;
            v = (rdata >> (8 * lane)) & 32'hFF;
            if (!uns && v > 32'd127) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            lane = (a % 4) / 2;
            v = (rdata >> (16 * lane)) & 32'hFFFF;
            if (!uns && v > 32'd32767) v = v - 32'd65536;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return 4'(3 << (2 * ((a % 4) / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // rv_dly < 0 means the bus never answers (timeout path).
    task automatic run_op(input logic ld, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input int rdy_dly, input int rv_dly);
        logic        misal;
        logic [37:0] e;
        logic [37:0] got;
        int          n;
        misal = model_misaligned(sz, a);
        if (misal || rv_dly < 0)  e = {1'b1, 5'd0, a};
        else if (ld)              e = {1'b0, rd, model_load(sz, uns, a, rdata)};
        else                      e = {1'b0, 5'd0, 32'd0};
        exp_q.push_back(e);

        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
        #1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        // Scramble the request bus: the unit must work from its latched copy.
        req_valid = 1'b0; req_load = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        #1;
        if (!misal) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                chk("mem_valid_req", {31'd0, mem_valid}, 32'd1);
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_we", {31'd0, mem_we}, {31'd0, ~ld});
                chk("mem_wstrb", {28'd0, mem_wstrb}, ld ? 32'd0 : {28'd0, model_strb(sz, a)});
                if (!ld) chk("mem_wdata", mem_wdata, model_wdata(sz, wd));
                if (i == rdy_dly) begin
                    mem_rvalid = 1'b0;
                    mem_ready  = 1'b1;
                end else begin
                    // Stray responses while requesting must be ignored.
                    mem_rvalid = 1'($urandom);
                    mem_rdata  = $urandom;
                end
                @(negedge clk);
                mem_ready = 1'b0; mem_rvalid = 1'b0;
                #1;
            end
            if (rv_dly >= 0) begin
                for (int i = 0; i < rv_dly; i++) begin
                    chk("resp_quiet_wait", {31'd0, resp_valid}, 32'd0);
                    mem_rdata = $urandom;
                    @(negedge clk);
                    #1;
                end
                mem_rvalid = 1'b1; mem_rdata = rdata;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = $urandom;
                #1;
            end else begin
                n = 0;
                while (resp_valid !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("timeout_wait_cycles", n, TMO);
            end
        end else begin
            chk("trap_no_mem_valid", {31'd0, mem_valid}, 32'd0);
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("resp_data", resp_data, got[31:0]);
            chk("resp_rd", {27'd0, resp_rd}, {27'd0, got[36:32]});
            chk("resp_err", {31'd0, resp_err}, {31'd0, got[37]});
        end
        @(negedge clk);
        #1;
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        // Reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);

        // Directed cases
        run_op(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 5'd7, 0, 0);  // LB
        run_op(1'b1, 2'd1, 1'b1, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 5'd8, 0, 0);  // LHU
        run_op(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 5'd9, 0, 0);  // LH
        run_op(1'b0, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'd0, 5'd3, 0, 0);  // SB
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h1234_5678, 32'd0, 5'd4, 5, 1);  // SW, stalled
        run_op(1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'd0, 32'hCAFE_F00D, 5'd5, 0, -1); // timeout
        run_op(1'b1, 2'd2, 1'b0, 32'h0000_1002, 32'd0, 32'h0102_0304, 5'd6, 0, 0);  // LW misaligned
        run_op(1'b1, 2'd3, 1'b1, 32'h0000_1000, 32'd0, 32'h5566_7788, 5'd10, 1, 0); // size=11

        // Flush in the accept cycle: not accepted.
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_size = 2'd2; req_addr = 32'h0000_6000; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_accept_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_accept_no_mem", {31'd0, mem_valid}, 32'd0);

        // Flush during REQ: bus completes, response is silent.
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_size = 2'd2; req_addr = 32'h0000_7000; req_rd = 5'd11;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        #1;
        chk("flush_req_mem_valid", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        flush = 1'b0; mem_ready = 1'b1;
        #1;
        chk("flush_req_still_valid", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("flush_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("flush_no_resp_late", {31'd0, resp_valid}, 32'd0);
        chk("flush_back_idle", {31'd0, req_ready}, 32'd1);

        // Reset mid-op abandons the bus request immediately.
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_size = 2'd2; req_addr = 32'h0000_8000;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("midrst_mem_valid_before", {31'd0, mem_valid}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra;
            ra = {16'd0, 16'($urandom)};
            run_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom, $urandom,
                   5'($urandom), $urandom_range(0, 3), $urandom_range(0, TMO - 2));
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
